// File: rtl/trng_health_monitor.sv
// Online RCT/APT health monitor between the raw TRNG bit source and the byte collector.
// Optional startup qualification (one clean APT window before forwarding) via HEALTH_STARTUP_EN.
module trng_health_monitor #(
    parameter int unsigned RCT_CUTOFF = 21,
    parameter int unsigned APT_WINDOW = 1024,
    parameter int unsigned APT_CUTOFF = 589
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic bit_i,
    input  logic bit_valid_i,
    input  logic clr_alarm_i,
    output logic bit_o,
    output logic bit_valid_o,
    output logic rct_fail_o,
    output logic apt_fail_o,
    output logic window_done_o,
    output logic alarm_o
);

    localparam int unsigned RctW = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned WinW = $clog2(APT_WINDOW + 1);

`ifdef HEALTH_STARTUP_EN
    typedef enum logic [1:0] {S_IDLE, S_STARTUP, S_RUN, S_ALARM} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ALARM} state_e;
`endif

    state_e            state_q, state_d;
    logic              rct_first_q, rct_first_d;
    logic              rct_prev_q, rct_prev_d;
    logic [RctW-1:0]   rct_cnt_q, rct_cnt_d;
    logic              apt_first_q, apt_first_d;
    logic              apt_ref_q, apt_ref_d;
    logic [WinW-1:0]   win_cnt_q, win_cnt_d;
    logic [WinW-1:0]   match_q, match_d;
    logic              bit_q, bit_d;
    logic              bit_valid_q, bit_valid_d;
    logic              rct_fail_q, rct_fail_d;
    logic              apt_fail_q, apt_fail_d;
    logic              win_done_q, win_done_d;
    logic              alarm_q, alarm_d;
    logic              active, accept, rct_hit, apt_hit;

    // Next-state: test counters, FSM and registered outputs
    always_comb begin
        state_d     = state_q;
        rct_first_d = rct_first_q;
        rct_prev_d  = rct_prev_q;
        rct_cnt_d   = rct_cnt_q;
        apt_first_d = apt_first_q;
        apt_ref_d   = apt_ref_q;
        win_cnt_d   = win_cnt_q;
        match_d     = match_q;
        bit_d       = bit_q;
        bit_valid_d = 1'b0;
        rct_fail_d  = 1'b0;
        apt_fail_d  = 1'b0;
        win_done_d  = 1'b0;
        alarm_d     = alarm_q;
        rct_hit     = 1'b0;
        apt_hit     = 1'b0;

`ifdef HEALTH_STARTUP_EN
        active = (state_q == S_RUN) || (state_q == S_STARTUP);
`else
        active = (state_q == S_RUN);
`endif
        accept = en_i & bit_valid_i & active;

        if (state_q == S_IDLE && en_i) begin
`ifdef HEALTH_STARTUP_EN
            state_d = S_STARTUP;
`else
            state_d = S_RUN;
`endif
        end

        if (accept) begin
            if (rct_first_q || (bit_i != rct_prev_q)) begin
                rct_first_d = 1'b0;
                rct_prev_d  = bit_i;
                rct_cnt_d   = RctW'(1);
            end else if (rct_cnt_q != RctW'(RCT_CUTOFF)) begin
                rct_cnt_d = rct_cnt_q + RctW'(1);
            end

            if (apt_first_q) begin
                apt_first_d = 1'b0;
                apt_ref_d   = bit_i;
                match_d     = WinW'(1);
                win_cnt_d   = WinW'(1);
            end else begin
                win_cnt_d = win_cnt_q + WinW'(1);
                if (bit_i == apt_ref_q) match_d = match_q + WinW'(1);
            end

            rct_hit = (rct_cnt_d == RctW'(RCT_CUTOFF));
            apt_hit = (match_d == WinW'(APT_CUTOFF));

            if (rct_hit || apt_hit) begin
                // The failing bit is swallowed; only the pulses and alarm escape
                state_d    = S_ALARM;
                alarm_d    = 1'b1;
                rct_fail_d = rct_hit;
                apt_fail_d = apt_hit;
            end else begin
                if (win_cnt_d == WinW'(APT_WINDOW)) begin
                    win_done_d  = 1'b1;
                    apt_first_d = 1'b1;
`ifdef HEALTH_STARTUP_EN
                    if (state_q == S_STARTUP) state_d = S_RUN;
`endif
                end
                if (state_q == S_RUN) begin
                    bit_valid_d = 1'b1;
                    bit_d       = bit_i;
                end
            end
        end

        // Clear wins over anything that happened this cycle, including a failure
        if (clr_alarm_i) begin
            state_d     = S_IDLE;
            rct_first_d = 1'b1;
            rct_prev_d  = 1'b0;
            rct_cnt_d   = '0;
            apt_first_d = 1'b1;
            apt_ref_d   = 1'b0;
            win_cnt_d   = '0;
            match_d     = '0;
            bit_valid_d = 1'b0;
            rct_fail_d  = 1'b0;
            apt_fail_d  = 1'b0;
            win_done_d  = 1'b0;
            alarm_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rct_first_q <= 1'b1;
            rct_prev_q  <= 1'b0;
            rct_cnt_q   <= '0;
            apt_first_q <= 1'b1;
            apt_ref_q   <= 1'b0;
            win_cnt_q   <= '0;
            match_q     <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            rct_fail_q  <= 1'b0;
            apt_fail_q  <= 1'b0;
            win_done_q  <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rct_first_q <= rct_first_d;
            rct_prev_q  <= rct_prev_d;
            rct_cnt_q   <= rct_cnt_d;
            apt_first_q <= apt_first_d;
            apt_ref_q   <= apt_ref_d;
            win_cnt_q   <= win_cnt_d;
            match_q     <= match_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            rct_fail_q  <= rct_fail_d;
            apt_fail_q  <= apt_fail_d;
            win_done_q  <= win_done_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bit_o         = bit_q;
    assign bit_valid_o   = bit_valid_q;
    assign rct_fail_o    = rct_fail_q;
    assign apt_fail_o    = apt_fail_q;
    assign window_done_o = win_done_q;
    assign alarm_o       = alarm_q;

endmodule
